rcv_timer_ctrl: RTL and testbench

Frame-timing controller for the serial receive path. It sequences an internal bit-period tick counter and a data-bit counter from a start-bit edge pulse. It emits mid-bit sample strobes for the shift register, a stop-bit strobe, and frame-complete and error flags. It sits between the start-edge detector and the receive shift register / receive FSM.

---
 rtl/rcv_timer_pkg.sv | 14 +
 rtl/rcv_timer_if.sv | 32 +++
 rtl/rcv_tick_counter.sv | 37 +++
 rtl/rcv_timer_ctrl.sv | 140 ++++++++++++++
 tb/tb_rcv_timer_ctrl.sv | 126 ++++++++++++
 5 files changed

// File: rtl/rcv_timer_pkg.sv
// Shared types and constants for the receive frame-timing controller.
package rcv_timer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_DONE  = 3'd4
    } rcv_timer_state_t;

    localparam int MIN_CLKS_PER_BIT = 2;

endpackage

// File: rtl/rcv_timer_if.sv
// Signal bundle between the start-edge detector / receive FSM side and the frame-timing controller.
interface rcv_timer_if #(
    parameter int CNT_W     = 4,
    parameter int DATA_BITS = 8
);
    localparam int IDX_W = $clog2(DATA_BITS + 1);

    logic             start_bit_detected;
    logic             serial_in;
    logic [CNT_W-1:0] clks_per_bit;
    logic             abort;
    logic             shift_strobe;
    logic             stop_strobe;
    logic [IDX_W-1:0] bit_index;
    logic             frame_busy;
    logic             frame_done;
    logic             framing_err;
    logic             start_err;

    modport master (
        output start_bit_detected, serial_in, clks_per_bit, abort,
        input  shift_strobe, stop_strobe, bit_index, frame_busy,
               frame_done, framing_err, start_err
    );

    modport slave (
        input  start_bit_detected, serial_in, clks_per_bit, abort,
        output shift_strobe, stop_strobe, bit_index, frame_busy,
               frame_done, framing_err, start_err
    );

endinterface

// File: rtl/rcv_tick_counter.sv
// Up-counter with synchronous clear and wrap back to CLEAR_VAL once it has reached rollover_val.
module rcv_tick_counter #(
    parameter int           W         = 4,
    parameter logic [W-1:0] CLEAR_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         count_enable,
    input  logic [W-1:0] rollover_val,
    output logic [W-1:0] count_out,
    output logic         at_rollover
);

    logic [W-1:0] count_q, count_d;

    assign at_rollover = (count_q == rollover_val);
    assign count_out   = count_q;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = CLEAR_VAL;
        end else if (count_enable) begin
            count_d = at_rollover ? CLEAR_VAL : count_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/rcv_timer_ctrl.sv
// Frame-timing controller: sequences start/data/stop bit periods and emits mid-bit sample strobes.
module rcv_timer_ctrl
    import rcv_timer_pkg::*;
#(
    parameter int CNT_W     = 4,
    parameter int DATA_BITS = 8
) (
    input  logic        clk,
    input  logic        rst,
    rcv_timer_if.slave  bus
);

    localparam int               IDX_W    = $clog2(DATA_BITS + 1);
    localparam logic [IDX_W-1:0] LAST_BIT = IDX_W'(DATA_BITS - 1);
    localparam logic [IDX_W-1:0] ALL_BITS = IDX_W'(DATA_BITS);
    localparam logic [CNT_W-1:0] MIN_P    = CNT_W'(MIN_CLKS_PER_BIT);

    rcv_timer_state_t state_q, state_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] half_q, half_d;
    logic             framing_err_q, framing_err_d;
    logic             start_err_q, start_err_d;

    logic [CNT_W-1:0] tickCount;
    logic             tickAtPeriod;
    logic             tickClear, tickEnable;
    logic [IDX_W-1:0] bitCount;
    logic             bitsFull;
    logic             bitClear;
    logic             shiftStrobe;

    assign tickEnable  = (state_q == ST_START) || (state_q == ST_DATA) || (state_q == ST_STOP);
    assign shiftStrobe = (state_q == ST_DATA) && tickAtPeriod && !bitsFull;

    rcv_tick_counter #(.W(CNT_W), .CLEAR_VAL(CNT_W'(1))) u_tick (
        .clk          (clk),
        .rst          (rst),
        .clear        (tickClear),
        .count_enable (tickEnable),
        .rollover_val (period_q),
        .count_out    (tickCount),
        .at_rollover  (tickAtPeriod)
    );

    // Bit counter never wraps: its rollover value is only reached once every data bit is in.
    rcv_tick_counter #(.W(IDX_W), .CLEAR_VAL('0)) u_bits (
        .clk          (clk),
        .rst          (rst),
        .clear        (bitClear),
        .count_enable (shiftStrobe),
        .rollover_val (ALL_BITS),
        .count_out    (bitCount),
        .at_rollover  (bitsFull)
    );

    always_comb begin
        state_d       = state_q;
        period_d      = period_q;
        half_d        = half_q;
        framing_err_d = framing_err_q;
        start_err_d   = 1'b0;
        tickClear     = 1'b0;
        bitClear      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.start_bit_detected) begin
                    period_d  = (bus.clks_per_bit < MIN_P) ? MIN_P : bus.clks_per_bit;
                    half_d    = period_d >> 1;
                    tickClear = 1'b1;
                    bitClear  = 1'b1;
                    state_d   = ST_START;
                end
            end
            ST_START: begin
                if (tickCount == half_q) begin
                    if (!bus.serial_in) begin
                        tickClear = 1'b1;
                        state_d   = ST_DATA;
                    end else begin
                        start_err_d = 1'b1;
                        state_d     = ST_IDLE;
                    end
                end
            end
            ST_DATA: begin
                if (shiftStrobe && (bitCount == LAST_BIT)) begin
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (tickAtPeriod) begin
                    framing_err_d = ~bus.serial_in;
                    state_d       = ST_DONE;
                end
            end
            ST_DONE: begin
                bitClear = 1'b1;
                state_d  = ST_IDLE;
            end
            default: begin
                bitClear = 1'b1;
                state_d  = ST_IDLE;
            end
        endcase

        // Abort wins over everything except reset and never produces a start error.
        if (bus.abort && (state_q != ST_IDLE)) begin
            state_d       = ST_IDLE;
            bitClear      = 1'b1;
            start_err_d   = 1'b0;
            framing_err_d = framing_err_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            period_q      <= MIN_P;
            half_q        <= MIN_P >> 1;
            framing_err_q <= 1'b0;
            start_err_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            period_q      <= period_d;
            half_q        <= half_d;
            framing_err_q <= framing_err_d;
            start_err_q   <= start_err_d;
        end
    end

    assign bus.shift_strobe = shiftStrobe;
    assign bus.stop_strobe  = (state_q == ST_STOP) && tickAtPeriod;
    assign bus.bit_index    = bitCount;
    assign bus.frame_busy   = tickEnable;
    assign bus.frame_done   = (state_q == ST_DONE);
    assign bus.framing_err  = (state_q == ST_DONE) && framing_err_q;
    assign bus.start_err    = start_err_q;

endmodule

// File: tb/tb_rcv_timer_ctrl.sv
// Directed bench for rcv_timer_ctrl: nominal, false-start, framing-error, clamped P, abort and reset frames.
module tb_rcv_timer_ctrl;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    rcv_timer_if #(.CNT_W(4), .DATA_BITS(8)) bus ();

    rcv_timer_ctrl #(.CNT_W(4), .DATA_BITS(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic sbd, input logic sin, input logic [3:0] cpb,
                                 input logic ab, input logic rs);
        bus.start_bit_detected = sbd;
        bus.serial_in          = sin;
        bus.clks_per_bit       = cpb;
        bus.abort              = ab;
        rst                    = rs;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic checkAll(input string tag, input int n, input logic eShift, input logic eStop,
                            input logic eDone, input logic eFerr, input logic eBusy,
                            input int eIdx, input logic eSerr);
        checkOutput($sformatf("%s.shift@%0d", tag, n), 32'(bus.shift_strobe), 32'(eShift));
        checkOutput($sformatf("%s.stop@%0d",  tag, n), 32'(bus.stop_strobe),  32'(eStop));
        checkOutput($sformatf("%s.done@%0d",  tag, n), 32'(bus.frame_done),   32'(eDone));
        checkOutput($sformatf("%s.ferr@%0d",  tag, n), 32'(bus.framing_err),  32'(eFerr));
        checkOutput($sformatf("%s.busy@%0d",  tag, n), 32'(bus.frame_busy),   32'(eBusy));
        checkOutput($sformatf("%s.idx@%0d",   tag, n), 32'(bus.bit_index),    32'(eIdx));
        checkOutput($sformatf("%s.serr@%0d",  tag, n), 32'(bus.start_err),    32'(eSerr));
    endtask

    // Start pulse at relative cycle 0; killAt < 0 means the frame runs to completion.
    task automatic runFrame(input string tag, input int cpb0, input int cpbLater, input int p,
                            input int h, input logic stopVal, input int killAt,
                            input logic killRst, input int ignStart);
        int   last;
        int   eIdx;
        logic eShift, eStop, eDone, eFerr, eBusy, sbd, sin;
        last = h + 9 * p + 2;
        for (int n = 0; n <= last; n++) begin
            sbd = (n == 0) || (n == ignStart) || ((n == last - 1) && (killAt < 0));
            sin = (n >= h + 8 * p + 1) ? stopVal : 1'b0;
            applyStimulus(sbd, sin, (n == 0) ? 4'(cpb0) : 4'(cpbLater),
                          (n == killAt) && !killRst, (n == killAt) && killRst);
            eShift = (n >= h + p) && (n <= h + 8 * p) && (((n - h) % p) == 0);
            eStop  = (n == h + 9 * p);
            eDone  = (n == last - 1);
            eFerr  = eDone && !stopVal;
            eBusy  = (n >= 1) && (n <= h + 9 * p);
            if (n == 0 || n >= last || n <= h + p) begin
                eIdx = 0;
            end else begin
                eIdx = (n - h - 1) / p;
                if (eIdx > 8) eIdx = 8;
            end
            if (killAt >= 0 && n > killAt) begin
                eShift = 1'b0; eStop = 1'b0; eDone = 1'b0; eFerr = 1'b0; eBusy = 1'b0; eIdx = 0;
            end
            checkAll(tag, n, eShift, eStop, eDone, eFerr, eBusy, eIdx, 1'b0);
            stepCycle();
        end
        applyStimulus(1'b0, 1'b1, 4'd10, 1'b0, 1'b0);
        stepCycle();
    endtask

    initial begin
        applyStimulus(1'b0, 1'b1, 4'd10, 1'b0, 1'b1);
        stepCycle();
        stepCycle();
        checkAll("reset", 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
        applyStimulus(1'b0, 1'b1, 4'd10, 1'b0, 1'b0);
        stepCycle();
        checkAll("postreset", 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0);

        $display("[TB] nominal frame P=10 with ignored start pulses in DATA and DONE");
        runFrame("nominal", 10, 10, 10, 5, 1'b1, -1, 1'b0, 30);

        $display("[TB] false start then immediate restart");
        for (int n = 0; n <= 8; n++) begin
            applyStimulus((n == 0) || (n == 6), (n >= 5), 4'd10, (n == 7), 1'b0);
            checkAll("falsestart", n, 1'b0, 1'b0, 1'b0, 1'b0,
                     ((n >= 1) && (n <= 5)) || (n == 7), 0, (n == 6));
            stepCycle();
        end
        applyStimulus(1'b0, 1'b1, 4'd10, 1'b0, 1'b0);
        stepCycle();

        $display("[TB] framing error on stop bit");
        runFrame("ferr", 10, 10, 10, 5, 1'b0, -1, 1'b0, -1);

        $display("[TB] odd and clamped bit periods");
        runFrame("odd3chg", 3, 12, 3, 1, 1'b1, -1, 1'b0, -1);
        runFrame("clamp1", 1, 1, 2, 1, 1'b1, -1, 1'b0, -1);
        runFrame("clamp0", 0, 9, 2, 1, 1'b1, -1, 1'b0, -1);

        $display("[TB] abort and reset mid-frame");
        runFrame("abort", 10, 10, 10, 5, 1'b1, 40, 1'b0, -1);
        runFrame("midreset", 10, 10, 10, 5, 1'b1, 50, 1'b1, -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
